// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Counter ports of dmem_responder are enabled by DMEM_ACCESS_COUNT_EN.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_e;

  // Request fields kept after accept; the word index is held separately
  // because its width follows the address parameter.
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half/word lane steering, load extension and misalignment/illegal detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_mask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [31:0] rshift;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rshift = rword >> {off, 3'b000};
  assign rbyte  = rshift[7:0];
  assign rhalf  = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_mask  = 4'b0000;
    wdata_lane = 32'd0;
    rdata_ext  = 32'd0;
    err        = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB: begin
          byte_mask  = 4'b0001 << off;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_SH: begin
          err        = off[0];
          byte_mask  = off[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
        end
        F3_SW: begin
          err        = |off;
          byte_mask  = 4'b1111;
          wdata_lane = wdata;
        end
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB:  rdata_ext = {{24{rbyte[7]}}, rbyte};
        F3_LBU: rdata_ext = {24'd0, rbyte};
        F3_LH: begin
          err       = off[0];
          rdata_ext = {{16{rhalf[15]}}, rhalf};
        end
        F3_LHU: begin
          err       = off[0];
          rdata_ext = {16'd0, rhalf};
        end
        F3_LW: begin
          err       = |off;
          rdata_ext = rword;
        end
        default: err = 1'b1;
      endcase
    end
    // A rejected store must never touch memory.
    if (err) byte_mask = 4'b0000;
  end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder with RISC-V lane alignment.
// Optional ld_count/st_count ports are built when DMEM_ACCESS_COUNT_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
`ifdef DMEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]           ld_count,
  output logic [15:0]           st_count
`endif
);

  localparam int IDX_W = DM_ADDRESS - 2;
  localparam int DEPTH = 1 << IDX_W;

  logic [DATA_W-1:0] mem [DEPTH];

  dmem_state_e      state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  dmem_req_t        req_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rword_reg;
  logic             accept;

  logic        la_we;
  logic [2:0]  la_funct3;
  logic [1:0]  la_off;
  logic [31:0] la_wdata;
  logic [3:0]  byte_mask;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;
  logic        la_err;

  assign req_ready = (state_reg == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = (state_reg == RESP);
  assign accept    = req_valid && req_ready;

  // In IDLE the aligner classifies the incoming request; afterwards it serves the latched one.
  assign la_we     = req_ready ? req_we     : req_reg.we;
  assign la_funct3 = req_ready ? req_funct3 : req_reg.funct3;
  assign la_off    = req_ready ? req_addr[1:0] : req_reg.off;
  assign la_wdata  = req_ready ? req_wdata  : req_reg.wdata;

  dmem_lane_align u_align (
    .we         (la_we),
    .funct3     (la_funct3),
    .off        (la_off),
    .wdata      (la_wdata),
    .rword      (rword_reg),
    .byte_mask  (byte_mask),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (la_err)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (la_err) begin
            state_next = RESP;
          end else if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end else begin
            state_next = ACCESS;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = ACCESS;
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_reg.we     <= req_we;
      req_reg.funct3 <= req_funct3;
      req_reg.off    <= req_addr[1:0];
      req_reg.wdata  <= req_wdata;
      idx_reg        <= req_addr[DM_ADDRESS-1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept && la_err) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (state_reg == ACCESS) begin
      rsp_rdata <= req_reg.we ? '0 : rdata_ext;
      rsp_err   <= 1'b0;
    end
  end

  // The read is launched one edge ahead so ACCESS sees a registered word.
  assign rd_idx = accept ? req_addr[DM_ADDRESS-1:2] : idx_reg;

  always_ff @(posedge clk) begin
    rword_reg <= mem[rd_idx];
    if (state_reg == ACCESS && req_reg.we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_mask[b]) mem[idx_reg][b*8 +: 8] <= wdata_lane[b*8 +: 8];
      end
    end
  end

`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] ld_count_reg, st_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_count_reg <= 16'd0;
      st_count_reg <= 16'd0;
    end else if (state_reg == RESP && !rsp_err) begin
      if (req_reg.we) begin
        if (st_count_reg != 16'hFFFF) st_count_reg <= st_count_reg + 16'd1;
      end else begin
        if (ld_count_reg != 16'hFFFF) ld_count_reg <= ld_count_reg + 16'd1;
      end
    end
  end

  assign ld_count = ld_count_reg;
  assign st_count = st_count_reg;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM-stage data-memory initiator (write enable, read enable, address, write data, funct3).
- Services one load or store at a time over a valid/ready request channel and a one-cycle response pulse.
- Inserts a configurable number of wait states, so the pipeline can be verified against a non-ideal memory.
- Performs RISC-V byte/half/word lane alignment, sign/zero extension and misalignment detection.

Parameters:
- DM_ADDRESS, 9, byte-address width; storage depth is 2**(DM_ADDRESS-2) words.
- DATA_W, 32, data width; only 32 is supported.
- WAIT_CYCLES, 2, wait states between accept and access; legal range 0..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; equals (state==IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  DM_ADDRESS  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- req_funct3  in  3  RISC-V funct3 of the load or store
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal funct3; qualified by rsp_valid
- busy  out  1  state!=IDLE; drives the pipeline stall
- ld_count  out  16  loads completed (only with DMEM_ACCESS_COUNT_EN)
- st_count  out  16  stores completed (only with DMEM_ACCESS_COUNT_EN)

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous, active-high.
- Reset values: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, counters=0. Storage contents are not cleared.
- Accept: a request is accepted on an edge where req_valid && req_ready. All request fields are latched at accept; the inputs are don't-care afterwards.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- From IDLE on accept:
  - Error request → RESP with rsp_err=1.
  - Otherwise, if WAIT_CYCLES>0 → WAIT with cnt=WAIT_CYCLES.
  - Otherwise → ACCESS.
- WAIT: cnt decrements each cycle; when cnt==1 the next state is ACCESS.
- ACCESS: the store write or the load read-and-extend happens on this edge; next state is RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The next request can be accepted in that IDLE cycle; there is no pipelining.
- Latency: accept in cycle T gives rsp_valid in cycle T+WAIT_CYCLES+2. An error gives rsp_valid in T+1.
- Error conditions:
  - Half access (LH/LHU/SH) with addr[0]!=0.
  - Word access (LW/SW) with addr[1:0]!=0.
  - Load funct3 of 3, 6 or 7.
  - Store funct3 greater than 2.
  - An errored store writes nothing.
- Word index: addr[DM_ADDRESS-1:2].
- Stores:
  - SB writes wdata[7:0] into byte lane addr[1:0].
  - SH writes wdata[15:0] into half lane addr[1].
  - SW writes the whole word.
  - Other lanes are preserved.
- Loads:
  - LB/LH sign-extend the selected lane; LBU/LHU zero-extend it.
  - LW returns the whole word.
- rsp_rdata holds its value until the next RESP.
- Boundaries:
  - The top address wraps nowhere: the word index is exact width.
  - req_valid held while not ready has no effect and must be held by the initiator.
  - Reset asserted in WAIT or ACCESS aborts the request: no write occurs and no response is produced.

Optional Feature:
- Macro: DMEM_ACCESS_COUNT_EN.
- Defined: ld_count/st_count increment on each non-error load/store RESP, saturating at 0xFFFF, and clear on reset.
- Undefined: the ports are absent and the counter logic is not compiled.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5, F3_SB=0, F3_SH=1, F3_SW=2.
  - State enum dmem_state_e {IDLE, WAIT, ACCESS, RESP}.
  - Latched-request struct dmem_req_t.
- Sub-module dmem_lane_align (combinational):
  - Inputs: funct3, addr[1:0], wdata, read word.
  - Outputs: 4-bit byte mask, lane-shifted write data, extended load data, misalign/illegal flag.

Test Plan:
- SW 0xDEADBEEF to 0x010, then LW 0x010 → rsp_rdata=0xDEADBEEF, rsp_err=0.
- SB 0x80 to 0x013 over that word, then LB 0x013 → 0xFFFFFF80; LBU → 0x00000080; LW → 0x80ADBEEF.
- LH at 0x011 → rsp_valid at T+1 with rsp_err=1; SH 0x1234 to 0x011 → err, and a following LW 0x010 still returns 0x80ADBEEF.
- WAIT_CYCLES=2, load accepted in cycle T → req_ready=0 and busy=1 for T+1..T+4, rsp_valid only in T+4; WAIT_CYCLES=0 → rsp_valid at T+2.
- SW 0x11111111 to 0x020, reset pulsed in the first WAIT cycle, then LW 0x020 → prior contents, not 0x11111111; no rsp_valid for the aborted store.
- With DMEM_ACCESS_COUNT_EN: 3 good loads, 2 good stores, 1 errored load → ld_count=3, st_count=2.
